// File: rtl/lock_sequencer.sv
// Canal-lock chamber sequencer: arbitrates low/high boat requests, drives both
// gates and issues single-cycle raise/lower commands to the water controller.
module lock_sequencer #(
  parameter int GATE_CYC  = 20,
  parameter int DWELL_CYC = 40,
  parameter int CW        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_low,
  input  logic req_high,
  input  logic boat_in,
  input  logic boat_out,
  input  logic water_high,
  input  logic water_low,
  output logic gate_low,
  output logic gate_high,
  output logic w_up,
  output logic w_down,
  output logic grant_low,
  output logic grant_high,
  output logic busy
);

  typedef enum logic [3:0] {
    IDLE, ADJ_IN, OPEN_IN, WAIT_IN, CLOSE_IN,
    ADJ_OUT, OPEN_OUT, WAIT_OUT, CLOSE_OUT, CLOSE_ABORT
  } state_t;

  localparam logic [CW-1:0] GATE_LAST  = CW'(GATE_CYC - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          side, side_nx;
  logic          last, last_nx;

  logic gate_done, ent_lvl, ext_lvl, pick, pick_lvl, any_req, lvl_valid;

  assign gate_done = (cnt == GATE_LAST);
  assign ent_lvl   = side ? water_high : water_low;
  assign ext_lvl   = side ? water_low  : water_high;
  assign any_req   = req_low | req_high;
  assign lvl_valid = water_high | water_low;
  // On a tie the side not served last time wins.
  assign pick      = (req_low & req_high) ? ~last : req_high;
  assign pick_lvl  = pick ? water_high : water_low;

  always_comb begin
    state_nx = state;
    side_nx  = side;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (any_req && lvl_valid) begin
          side_nx  = pick;
          state_nx = pick_lvl ? OPEN_IN : ADJ_IN;
        end
      end
      ADJ_IN:   if (ent_lvl)   state_nx = OPEN_IN;
      OPEN_IN:  if (gate_done) state_nx = WAIT_IN;
      WAIT_IN: begin
        if (boat_in)                 state_nx = CLOSE_IN;
        else if (cnt == DWELL_LAST)  state_nx = CLOSE_ABORT;
      end
      CLOSE_IN: if (gate_done) state_nx = ADJ_OUT;
      ADJ_OUT:  if (ext_lvl)   state_nx = OPEN_OUT;
      OPEN_OUT: if (gate_done) state_nx = WAIT_OUT;
      WAIT_OUT: if (boat_out)  state_nx = CLOSE_OUT;
      CLOSE_OUT, CLOSE_ABORT: begin
        if (gate_done) begin
          state_nx = IDLE;
          last_nx  = side;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // cnt saturates so a long ADJ wait never wraps back to 0 and re-pulses w_*.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      side  <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      side  <= side_nx;
      last  <= last_nx;
      if (state_nx != state) cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + 1'b1;
    end
  end

  logic ent_open, ext_open, adj_first;

  always_comb begin
    ent_open   = (state == OPEN_IN)  || (state == WAIT_IN);
    ext_open   = (state == OPEN_OUT) || (state == WAIT_OUT);
    adj_first  = (cnt == '0);
    busy       = (state != IDLE);
    gate_low   = (ent_open && !side) || (ext_open && side);
    gate_high  = (ent_open && side)  || (ext_open && !side);
    w_up       = adj_first && (((state == ADJ_IN) && side) || ((state == ADJ_OUT) && !side));
    w_down     = adj_first && (((state == ADJ_IN) && !side) || ((state == ADJ_OUT) && side));
    grant_low  = busy && !side;
    grant_high = busy && side;
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: transit-level predictor building expected per-cycle
// output traces, driven by a directed table, random transits and reset cases.
module tb_lock_sequencer;
  localparam int GATE  = 4;
  localparam int DWELL = 8;
  localparam int WMOVE = 10;
  localparam int ADJ_LEN = 1 + WMOVE + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_low = 0, req_high = 0, boat_in = 0, boat_out = 0;
  logic water_high, water_low;
  logic gate_low, gate_high, w_up, w_down, grant_low, grant_high, busy;

  always #5 clk = ~clk;

  lock_sequencer #(.GATE_CYC(GATE), .DWELL_CYC(DWELL), .CW(8)) dut (
    .clk(clk), .reset(reset), .req_low(req_low), .req_high(req_high),
    .boat_in(boat_in), .boat_out(boat_out),
    .water_high(water_high), .water_low(water_low),
    .gate_low(gate_low), .gate_high(gate_high), .w_up(w_up), .w_down(w_down),
    .grant_low(grant_low), .grant_high(grant_high), .busy(busy));

  // Water controller: a command starts a WMOVE-cycle move, both flags 0 meanwhile.
  bit wlvl = 0, wmov = 0, wtgt = 0, wen = 1;
  int wtmr = 0;
  always @(posedge clk) begin
    if (wmov) begin
      if (wtmr == 1) begin wmov <= 0; wlvl <= wtgt; end
      else wtmr <= wtmr - 1;
    end else if (w_up && !wlvl) begin
      wmov <= 1; wtgt <= 1; wtmr <= WMOVE;
    end else if (w_down && wlvl) begin
      wmov <= 1; wtgt <= 0; wtmr <= WMOVE;
    end
  end
  assign water_high = wen && !wmov && wlvl;
  assign water_low  = wen && !wmov && !wlvl;

  wire [6:0] outs = {gate_low, gate_high, w_up, w_down, grant_low, grant_high, busy};

  int n_tests = 0, n_fail = 0;
  bit last_m = 1;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected outputs from served side, which gate (entry/exit) is open, and w_* commands.
  function automatic logic [6:0] ev(bit s, bit ge, bit gx, bit wu, bit wd);
    return {(ge && !s) || (gx && s), (ge && s) || (gx && !s), wu, wd, !s, s, 1'b1};
  endfunction

  task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t outs=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(logic [6:0] exp, bit rl, bit rh, bit bi, bit bo, string nm);
    @(negedge clk);
    chk(nm, outs, exp);
    req_low = rl; req_high = rh; boat_in = bi; boat_out = bo;
  endtask

  task automatic seg(int n, logic [6:0] exp, string nm);
    for (int i = 0; i < n; i++) cyc(exp, rb(), rb(), rb(), rb(), nm);
  endtask

  task automatic do_reset_mid();
    #2 reset = 1;
    #1 chk("rst_async", outs, 7'b0);
    req_low = 0; req_high = 0; boat_in = 0; boat_out = 0;
    @(negedge clk);
    chk("rst_hold", outs, 7'b0);
    reset = 0;
    last_m = 1;
  endtask

  // One complete transit; rst_at >= 0 asserts reset that many cycles into WAIT_OUT.
  task automatic transit(bit rl, bit rh, bit s, bit adj, int bin_d, int bout_d, int rst_at);
    cyc(7'b0, rl, rh, 0, 0, "idle");
    if (adj) begin
      cyc(ev(s, 0, 0, s, !s), rb(), rb(), rb(), rb(), "adj_in_cmd");
      seg(ADJ_LEN - 1, ev(s, 0, 0, 0, 0), "adj_in");
    end
    seg(GATE, ev(s, 1, 0, 0, 0), "open_in");
    if (bin_d < DWELL) begin
      for (int i = 0; i < bin_d; i++) cyc(ev(s, 1, 0, 0, 0), rb(), rb(), 0, rb(), "wait_in");
      cyc(ev(s, 1, 0, 0, 0), rb(), rb(), 1, rb(), "wait_in_end");
      seg(GATE, ev(s, 0, 0, 0, 0), "close_in");
      cyc(ev(s, 0, 0, !s, s), rb(), rb(), rb(), rb(), "adj_out_cmd");
      seg(ADJ_LEN - 1, ev(s, 0, 0, 0, 0), "adj_out");
      seg(GATE, ev(s, 0, 1, 0, 0), "open_out");
      for (int i = 0; i < bout_d; i++) begin
        if (i == rst_at) begin do_reset_mid(); return; end
        cyc(ev(s, 0, 1, 0, 0), rb(), rb(), rb(), 0, "wait_out");
      end
      cyc(ev(s, 0, 1, 0, 0), rb(), rb(), rb(), 1, "wait_out_end");
      seg(GATE, ev(s, 0, 0, 0, 0), "close_out");
    end else begin
      for (int i = 0; i < DWELL; i++) cyc(ev(s, 1, 0, 0, 0), rb(), rb(), 0, rb(), "wait_in_to");
      seg(GATE, ev(s, 0, 0, 0, 0), "close_abort");
    end
    last_m = s;
  endtask

  typedef struct {
    bit rl, rh;
    int bin_d, bout_d;
    bit exp_side, exp_adj;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 0, 2, 3, 0, 0};   // plain low transit, no entry adjust
    tbl[1] = '{0, 1, 9, 0, 1, 0};   // high, abort (no boat_in)
    tbl[2] = '{1, 1, 7, 0, 0, 1};   // tie -> low; boat_in on timeout cycle
    tbl[3] = '{1, 1, 1, 2, 1, 0};   // tie -> high
    tbl[4] = '{1, 1, 0, 0, 0, 0};   // tie -> low
    tbl[5] = '{1, 0, 9, 0, 0, 1};   // low with lowering first, abort
    tbl[6] = '{0, 1, 3, 5, 1, 1};   // high from low water: raise first
    tbl[7] = '{1, 1, 8, 0, 0, 0};   // tie -> low, abort
    tbl[8] = '{1, 1, 4, 1, 1, 1};   // tie after abort goes to high

    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 7'b0);
    reset = 0;
    cyc(7'b0, 0, 0, 1, 1, "idle_after_reset");
    cyc(7'b0, 0, 0, 0, 0, "idle_ignore_boat");

    for (int i = 0; i < 9; i++)
      transit(tbl[i].rl, tbl[i].rh, tbl[i].exp_side, tbl[i].exp_adj,
              tbl[i].bin_d, tbl[i].bout_d, -1);

    // No grant while the water level is unknown.
    wen = 0;
    for (int i = 0; i < 3; i++) cyc(7'b0, 1, 1, 0, 0, "blocked");
    cyc(7'b0, 0, 0, 0, 0, "blocked_idle");
    wen = 1;

    for (int k = 0; k < 20; k++) begin
      bit rl, rh, s;
      int gap;
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) cyc(7'b0, 0, 0, 0, 0, "gap");
      rl = rb(); rh = rb();
      if (!rl && !rh) rl = 1;
      s = (rl && rh) ? !last_m : rh;
      transit(rl, rh, s, wlvl != s, $urandom_range(0, 10), $urandom_range(0, 6), -1);
    end

    // Reset during WAIT_OUT, then low must win the next tie.
    transit(0, 1, 1, wlvl != 1, 1, 6, 3);
    cyc(7'b0, 0, 0, 0, 0, "idle_post_rst");
    transit(1, 1, 0, wlvl != 0, 2, 1, -1);
    cyc(7'b0, 0, 0, 0, 0, "final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Top-level sequencer for the canal-lock chamber. It arbitrates boat requests from the downstream (low) and upstream (high) sides and drives both gate commands. It also issues the single-cycle `w_up`/`w_down` commands to the water-level controller, using that controller's `water_high`/`water_low` flags as completion status. Each request moves one boat through the chamber: bring the water to the entry level, open the entry gate, admit the boat, close, change level, open the exit gate, release, close.

## Interface
- `GATE_CYC`, default 20: cycles a gate takes to fully open or close; every OPEN_*/CLOSE_* state lasts exactly this long.
- `DWELL_CYC`, default 40: maximum cycles the entry gate waits open for `boat_in` before aborting.
- `CW`, default 8: width of the internal cycle counter; must hold max(`GATE_CYC`, `DWELL_CYC`).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces the idle state and all outputs to 0.
- `req_low`  in  1  level; a boat is waiting on the downstream side.
- `req_high`  in  1  level; a boat is waiting on the upstream side.
- `boat_in`  in  1  pulse; the boat is fully inside the chamber.
- `boat_out`  in  1  pulse; the boat is clear of the chamber.
- `water_high`  in  1  chamber at upstream level (from water controller).
- `water_low`  in  1  chamber at downstream level (from water controller).
- `gate_low`  out  1  open command, downstream gate.
- `gate_high`  out  1  open command, upstream gate.
- `w_up`  out  1  one-cycle raise command.
- `w_down`  out  1  one-cycle lower command.
- `grant_low`  out  1  downstream request is being served.
- `grant_high`  out  1  upstream request is being served.
- `busy`  out  1  state is not IDLE.

## Operation
- Registers: `state`, `cnt[CW-1:0]`, `side` (0 = low, 1 = high; side being served), `last` (side last served).
- Outputs are Moore-decoded from the registered state.
- `cnt` clears on every state change and increments otherwise.
- Notation: E = entry side = `side`; X = exit side = the opposite side.
- State transitions:
  - **IDLE**: requests are sampled only here.
    - If exactly one request is set, serve that side.
    - If both are set, serve the side opposite `last`.
    - No request is granted while `water_high` and `water_low` are both 0.
    - On a grant: if the chamber is already at E's level, go to OPEN_IN; otherwise go to ADJ_IN.
  - **ADJ_IN**: wait for E's level flag, then go to OPEN_IN.
  - **OPEN_IN**: `GATE_CYC` cycles, then WAIT_IN.
  - **WAIT_IN**: on `boat_in`, go to CLOSE_IN. When `cnt == DWELL_CYC-1` without `boat_in`, go to CLOSE_ABORT. If both happen in the same cycle, `boat_in` wins.
  - **CLOSE_IN**: `GATE_CYC` cycles, then ADJ_OUT.
  - **ADJ_OUT**: wait for X's level flag, then go to OPEN_OUT.
  - **OPEN_OUT**: `GATE_CYC` cycles, then WAIT_OUT.
  - **WAIT_OUT**: wait for `boat_out`; there is no timeout. Then go to CLOSE_OUT.
  - **CLOSE_OUT**, **CLOSE_ABORT**: `GATE_CYC` cycles, then IDLE, with `last <= side`.
- Output decode:
  - `gate_<E>` is 1 in OPEN_IN and WAIT_IN.
  - `gate_<X>` is 1 in OPEN_OUT and WAIT_OUT.
  - Both gates are 0 in every other state. Both gates are never 1 together.
  - `w_up` or `w_down` is 1 only in an ADJ state with `cnt == 0`. The direction is toward the target level: up for the high side, down for the low side.
  - `grant_<side>` is 1 in every state except IDLE.
- `boat_in`/`boat_out` outside their WAIT state are ignored.
- Request changes outside IDLE are ignored.

## Timing
- Reset values: state IDLE, `cnt` 0, `last` = high (so low wins the first tie), `side` 0, all outputs 0.
- Reset assertion mid-operation closes both gates immediately, asynchronously.
- Grant latency: a request sampled at edge N produces `grant_*` and the next state (OPEN_IN or ADJ_IN) from cycle N+1.
- No-adjust path: the gate opens in the cycle after the grant edge.
- `w_*` pulses for exactly 1 cycle per ADJ entry. It is never repeated while waiting.
- Each gate state lasts exactly `GATE_CYC` cycles. WAIT_IN lasts at most `DWELL_CYC` cycles.
- A served transit returns to IDLE; a new request can be granted at the first IDLE edge.

## Test plan
Bench parameters: `GATE_CYC`=4, `DWELL_CYC`=8, with a behavioural water model that takes 10 cycles.

- Reset, then `water_low`=1, pulse `req_low` -> `gate_low`=1 for 4 cycles of OPEN_IN. After `boat_in`: `gate_low`=0, then a 1-cycle `w_up`. After `water_high`: `gate_high` opens. After `boat_out`: closes, `busy`=0.
- `water_low`=1, `req_high` only -> `w_up` pulses 1 cycle, no gate opens until `water_high`, then `gate_high`=1.
- `req_low` and `req_high` both held -> served in order low, high, low. Each grant is one-hot.
- No `boat_in` after the entry gate opens -> gate held 8 cycles, 4-cycle close, IDLE. `w_*` never asserted; the next tie goes to the other side.
- `boat_in` in the same cycle as the dwell timeout -> CLOSE_IN path taken, not abort.
- Assert `reset` during WAIT_OUT -> all outputs 0 in that cycle. The FSM restarts in IDLE with low priority.
